// File: rtl/mealey_differ_pkg.sv
// Shared types for the Mealy differencer: FSM states, the signed sample type,
// the emit-counter width and the 10-bit to 9-bit reduction helper.
package Mealey_types;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    typedef logic signed [8:0] sample_t;

    localparam int COUNT_W = 16;

    localparam sample_t SAMPLE_MAX = 9'sd255;
    localparam sample_t SAMPLE_MIN = -9'sd256;

    // The difference overflows 9 bits exactly when its top two bits disagree.
    function automatic sample_t reduce_diff(input logic signed [9:0] diff, input bit sat_en);
        if (sat_en && (diff[9] != diff[8]))
            return diff[9] ? SAMPLE_MIN : SAMPLE_MAX;
        return diff[8:0];
    endfunction

endpackage

// File: rtl/mealey_outreg.sv
// Single-stage valid/ready output register: loads when empty or being drained,
// otherwise holds its contents stable.
module mealey_outreg
    import Mealey_types::*;
(
    input  logic    system1000,
    input  logic    system1000_rst,
    input  logic    load,
    input  sample_t load_data,
    input  logic    out_ready,
    output logic    in_ready,
    output logic    out_valid,
    output sample_t out_data
);

    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= load;
            if (load)
                out_data <= load_data;
        end
    end

endmodule

// File: rtl/mealey_differ.sv
// Mealy differencer: out[n] = in[n] - in[n-1], inverse of the wrapping 9-bit
// accumulator. Define MEALEY_DIFFER_SAT_EN to clamp instead of wrap.
module mealey_differ
    import Mealey_types::*;
(
    input  logic               system1000,
    input  logic               system1000_rst,
    input  logic               in_valid,
    input  sample_t            in_data,
    output logic               in_ready,
    input  logic               clr,
    output logic               out_valid,
    output sample_t            out_data,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count_o,
    output logic               sat_o
);

    state_t            state, state_next;
    sample_t           prev;
    sample_t           base;
    logic signed [9:0] diff;
    sample_t           diff_out;
    logic              accept;
    logic              emit;

`ifdef MEALEY_DIFFER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // A clear in the same cycle as an accept differences against zero.
    assign base     = clr ? sample_t'(0) : prev;
    assign diff     = {in_data[8], in_data} - {base[8], base};
    assign diff_out = reduce_diff(diff, SAT_EN);

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state   <= IDLE;
            prev    <= '0;
            count_o <= '0;
        end else begin
            state <= state_next;
            if (accept)
                prev <= in_data;
            else if (clr)
                prev <= '0;
            if (emit)
                count_o <= count_o + 1'b1;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = RUN;
            end
            RUN, STALL: begin
                if (accept)
                    state_next = RUN;
                else if (clr)
                    state_next = IDLE;
                else if (out_valid && !out_ready)
                    state_next = STALL;
                else
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MEALEY_DIFFER_SAT_EN
    logic sat_q;

    always_ff @(posedge system1000) begin
        if (system1000_rst)
            sat_q <= 1'b0;
        else if (accept && (diff[9] != diff[8]))
            sat_q <= 1'b1;
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

    mealey_outreg u_outreg (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .load           (accept),
        .load_data      (diff_out),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data)
    );

endmodule

// File: tb/tb_mealey_differ.sv
// Scoreboard bench for mealey_differ; expected differences are queued on accept
// and compared on emit. Works for both the wrap and MEALEY_DIFFER_SAT_EN builds.
module tb_mealey_differ;
    import Mealey_types::*;

    logic         system1000 = 1'b0;
    logic         system1000_rst;
    logic         in_valid;
    sample_t      in_data;
    logic         in_ready;
    logic         clr;
    logic         out_valid;
    sample_t      out_data;
    logic         out_ready;
    logic [15:0]  count_o;
    logic         sat_o;

    int      checks   = 0;
    int      failures = 0;
    sample_t exp_q[$];
    sample_t model_prev = '0;
    logic [15:0] model_count = '0;
    logic    model_sat = 1'b0;

    always #5 system1000 = ~system1000;

    mealey_differ dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .clr            (clr),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .count_o        (count_o),
        .sat_o          (sat_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and scoreboard, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge system1000);
            if (system1000_rst) begin
                exp_q.delete();
                model_prev  = '0;
                model_count = '0;
                model_sat   = 1'b0;
            end else begin
                check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        check("spurious_out", 1, 0);
                    else
                        check("out_data", int'(out_data), int'(exp_q.pop_front()));
                    model_count = model_count + 16'd1;
                end
                if (in_valid && in_ready) begin
                    int d;
                    sample_t e;
                    d = int'(in_data) - (clr ? 0 : int'(model_prev));
                    e = sample_t'(d);
`ifdef MEALEY_DIFFER_SAT_EN
                    if (d > 255) begin
                        e = 9'sd255;
                        model_sat = 1'b1;
                    end else if (d < -256) begin
                        e = -9'sd256;
                        model_sat = 1'b1;
                    end
`endif
                    exp_q.push_back(e);
                    model_prev = in_data;
                end else if (clr) begin
                    model_prev = '0;
                end
            end
        end
    end

    task automatic step();
        @(posedge system1000);
        #1;
    endtask

    task automatic drive(input logic v, input sample_t d, input logic c);
        in_valid = v;
        in_data  = d;
        clr      = c;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            step();
        if (exp_q.size() != 0)
            check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        system1000_rst = 1'b1;
        out_ready      = 1'b1;
        drive(1'b0, '0, 1'b0);
        step();
        step();
        system1000_rst = 1'b0;

        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_count", int'(count_o), 0);
        check("rst_sat", int'(sat_o), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Basic stream: 3, 7, 4 -> 3, 4, -3
        drive(1'b1, 9'sd3, 1'b0); step();
        check("basic_0", int'(out_data), 3);
        drive(1'b1, 9'sd7, 1'b0); step();
        check("basic_1", int'(out_data), 4);
        drive(1'b1, 9'sd4, 1'b0); step();
        check("basic_2", int'(out_data), -3);
        drain();
        check("basic_count", int'(count_o), 3);

        // Backpressure: 10 held for three cycles, then 10, 2
        drive(1'b0, '0, 1'b1); step();
        out_ready = 1'b0;
        drive(1'b1, 9'sd10, 1'b0); step();
        drive(1'b1, 9'sd12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_data", int'(out_data), 10);
            check("bp_in_ready", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_second", int'(out_data), 2);
        drain();

        // Clear with simultaneous accept
        drive(1'b1, 9'sd100, 1'b0); step();
        drive(1'b1, 9'sd5, 1'b1); step();
        check("clr_accept", int'(out_data), 5);
        drive(1'b1, 9'sd8, 1'b0); step();
        check("clr_next", int'(out_data), 3);
        drain();

        // Overflow boundary: 255 then -256
        drive(1'b0, '0, 1'b1); step();
        drive(1'b1, 9'sd255, 1'b0); step();
        check("bnd_first", int'(out_data), 255);
        drive(1'b1, -9'sd256, 1'b0); step();
`ifdef MEALEY_DIFFER_SAT_EN
        check("bnd_diff", int'(out_data), -256);
        check("bnd_sat", int'(sat_o), 1);
`else
        check("bnd_diff", int'(out_data), 1);
        check("bnd_sat", int'(sat_o), 0);
`endif
        drive(1'b1, -9'sd250, 1'b0); step();
        check("bnd_after", int'(out_data), 6);
        check("bnd_sat_held", int'(sat_o), int'(model_sat));
        drain();

        // Reset while stalled
        out_ready = 1'b0;
        drive(1'b1, 9'sd50, 1'b0); step();
        drive(1'b0, '0, 1'b0); step();
        step();
        check("stall_valid", int'(out_valid), 1);
        system1000_rst = 1'b1;
        step();
        system1000_rst = 1'b0;
        check("stall_rst_valid", int'(out_valid), 0);
        check("stall_rst_count", int'(count_o), 0);
        check("stall_rst_sat", int'(sat_o), 0);
        out_ready = 1'b1;
        step();
        step();
        check("stall_no_output", int'(out_valid), 0);

        // Counter wrap after 65536 emits
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, sample_t'($urandom_range(0, 511)), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        step();
        check("count_wrap", int'(count_o), 0);
        check("count_model", int'(count_o), int'(model_count));
        check("queue_empty", exp_q.size(), 0);
        check("sat_final", int'(sat_o), int'(model_sat));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mealey_differ.md
MEALEY_DIFFER -- requirements
Module: mealey_differ

Interface
REQ-001 SHALL have `system1000`, input, 1 bit: the single clock; all logic on its rising edge.
REQ-002 SHALL have `system1000_rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `in_valid`, input, 1 bit: accumulated sample is present on `in_data`.
REQ-004 SHALL have `in_data`, input, signed 9 bits: accumulated-stream sample.
REQ-005 SHALL have `in_ready`, output, 1 bit: block accepts `in_data` this cycle.
REQ-006 SHALL have `clr`, input, 1 bit: restart differencing, so the history value is 0.
REQ-007 SHALL have `out_valid`, output, 1 bit: `out_data` holds a recovered sample.
REQ-008 SHALL have `out_data`, output, signed 9 bits: recovered increment.
REQ-009 SHALL have `out_ready`, input, 1 bit: downstream takes `out_data` this cycle.
REQ-010 SHALL have `count_o`, output, 16 bits: number of samples emitted since reset.
REQ-011 SHALL have `sat_o`, output, 1 bit: sticky saturation flag (see Configuration).

Function
REQ-012 SHALL compute out[n] = in[n] - in[n-1], where in[-1] = 0; this is the inverse of the team's wrapping 9-bit accumulator.
REQ-013 SHALL accept a sample when `in_valid` && `in_ready`, and emit a sample when `out_valid` && `out_ready`.
REQ-014 SHALL drive `in_ready` = !`out_valid` || `out_ready`, combinationally; the pipeline holds one register stage and no skid buffer.
REQ-015 SHALL have a latency of 1 cycle: a sample accepted in cycle t SHALL appear on `out_data` with `out_valid`=1 in cycle t+1.
REQ-016 SHALL hold `out_data` and `out_valid` stable while `out_valid` && !`out_ready`.
REQ-017 SHALL store each accepted `in_data` in the history register `prev`.
REQ-018 SHALL implement three states:
  - IDLE: after reset or `clr`; `prev` = 0; `out_valid` = 0.
  - RUN: last output consumed or none pending.
  - STALL: `out_valid` && !`out_ready`.
REQ-019 SHALL use these transitions:
  - IDLE -> RUN on accept.
  - RUN -> STALL when the output is valid and not taken.
  - STALL -> RUN when the output is taken.
  - Any state -> IDLE on `clr` with no accept.
REQ-020 SHALL handle `clr` together with an accept in the same cycle as follows: the accepted sample is differenced against 0, `prev` becomes `in_data`, and the state is RUN.
REQ-021 SHALL NOT drop or modify a pending output on `clr`.
REQ-022 SHALL form the difference at 10 bits and reduce it to 9 bits per the Configuration section.
  - Example: -256 minus 255 is -511 at 10 bits, which wraps to +1.
REQ-023 SHALL increment `count_o` on each emit and wrap from 65535 to 0; `clr` SHALL NOT affect `count_o`.

Reset
REQ-024 SHALL, while `system1000_rst`=1 at a clock edge, set: state = IDLE, `prev` = 0, `out_valid` = 0, `out_data` = 0, `count_o` = 0, `sat_o` = 0.
REQ-025 SHALL drive `in_ready` = 1 in the first cycle after reset.
REQ-026 SHALL discard any in-flight sample when reset is applied mid-stream; no output SHALL follow for it.

Configuration
REQ-027 SHALL, when macro MEALEY_DIFFER_SAT_EN is defined, clamp the 10-bit difference to [-256, 255]; `sat_o` SHALL be set when a clamp occurs and stay set until reset.
REQ-028 SHALL, when MEALEY_DIFFER_SAT_EN is undefined, wrap the difference to 9 bits (two's complement) and tie `sat_o` to 0.

Structure
REQ-029 SHALL place the state enum (IDLE, RUN, STALL), the sample typedef (signed 9-bit) and the count width constant in the shared package `Mealey_types`.
REQ-030 SHALL implement the single-stage valid/ready output register as sub-module `mealey_outreg`; the FSM, `prev`, the arithmetic and `count_o` SHALL remain in `mealey_differ`.

Verification
REQ-031 Basic: reset, then feed 3, 7, 4 with `out_ready`=1 -> outputs 3, 4, -3 in consecutive cycles; `count_o` = 3.
REQ-032 Backpressure: feed 10, 12 with `out_ready`=0 for 3 cycles -> `out_data` stays 10, `in_ready` stays 0; after release, outputs 10 then 2.
REQ-033 Clear with simultaneous accept: `prev`=100, then `clr`=1 with an accept of 5 -> output 5; the next input 8 -> output 3.
REQ-034 Boundary, wrap build: inputs 255 then -256 -> output 1 (wrapped), `sat_o`=0.
REQ-035 Boundary, saturating build: inputs 255 then -256 -> output -256, `sat_o`=1 and held.
REQ-036 Reset and counter: reset while in STALL -> `out_valid`=0 next cycle, `count_o`=0; separately, 65536 emits -> `count_o` wraps to 0.
